muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair beside the single-cycle ALU. It accepts one mult/div operation via a start pulse, iterates one bit per clock over a shared shift/add-subtract datapath, and writes the 64-bit result into HI/LO. The decode and stall logic use busy_o to hold the pipeline and done_o to release it. HI/LO can also be written directly for move-to-HI/LO instructions.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  in  1  clock; all state updates on the rising edge
- rst_b  in  1  reset, asynchronous, active-high
- start_i  in  1  start request; sampled only in IDLE
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a_i  in  WIDTH  rs operand: multiplicand or dividend
- b_i  in  WIDTH  rt operand: multiplier or divisor
- hi_we_i  in  1  direct write of HI from wdata_i (MTHI)
- lo_we_i  in  1  direct write of LO from wdata_i (MTLO)
- wdata_i  in  WIDTH  direct-write data
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- hi_o  out  WIDTH  HI register: product high word, or remainder
- lo_o  out  WIDTH  LO register: product low word, or quotient
- div_by_zero_o  out  1  sticky flag; set by a DIV/DIVU with b=0, cleared by the next accepted start

## Operation
- The FSM has five states: IDLE, PREP, RUN, FIX, DONE.
- IDLE to PREP: on start_i. At this edge, a_i, b_i and op_i are latched; later changes on the inputs have no effect.
- PREP:
  - For signed ops, latch |a| and |b| as unsigned WIDTH-bit values and record the result signs.
    - Product sign = sa^sb.
    - Quotient sign = sa^sb.
    - Remainder sign = sa.
  - Clear the 2*WIDTH accumulator and set the counter to 0.
  - For a divide with b=0, go directly to DONE with HI=a, LO=all ones, and set div_by_zero_o.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Go to FIX when counter == WIDTH-1.
- FIX:
  - Negate the 64-bit product, the quotient and/or the remainder according to the recorded signs.
  - Division truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF (signed) yields LO=0x80000000, HI=0, with no trap.
- DONE: HI/LO are written on entry. done_o is high for this one cycle. Next state is IDLE.
- start_i outside IDLE is ignored. It is not queued.
- Direct writes:
  - hi_we_i/lo_we_i take effect only in IDLE. They are ignored while busy.
  - A direct write and start_i in the same IDLE cycle: the write lands, the start is accepted, and the result later overwrites HI/LO.

## Timing
- Start edge E0 (IDLE to PREP), then E1 (PREP to RUN) and E2..E(WIDTH+1) for RUN, reaching FIX at E(WIDTH+1).
- E(WIDTH+2): FIX to DONE; HI/LO updated.
- done_o is high in the cycle after E(WIDTH+2), i.e. after E34 for WIDTH=32. The FSM returns to IDLE at E(WIDTH+3).
- Divide by zero: PREP to DONE at E1, so done_o is high after E1.
- busy_o rises in the cycle after E0 and falls at the DONE to IDLE edge. A new start is accepted from the first IDLE cycle.
- Reset, at any time including mid-operation:
  - state=IDLE;
  - HI=LO=0;
  - busy_o=done_o=div_by_zero_o=0;
  - the accumulator and counter are cleared.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are fully supported as above.
- MULDIV_DIV_EN undefined:
  - The restoring-divide logic is not compiled.
  - A DIV/DIVU start goes IDLE to DONE in one edge with HI/LO unchanged.
  - div_by_zero_o is tied to 0.
  - MULT/MULTU are unaffected.

## Structure
- The shared package alu_pkg holds:
  - the op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state enum;
  - the default WIDTH constant.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-or-skip for multiply, trial subtract for divide) on the accumulator. Instantiated once; the FSM, counter, sign handling and HI/LO stay in the top.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o high exactly WIDTH+2 edges after start; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> done_o after E1, HI=0x1234, LO=0xFFFFFFFF, div_by_zero_o=1. The next start clears the flag.
- start_i pulsed at RUN cycle 10, and hi_we_i with wdata_i=0xDEAD while busy -> both ignored; first result intact, one done_o pulse only.
- rst_b asserted at RUN cycle 16 -> busy_o, done_o, HI, LO immediately 0. A fresh MULTU 6*7 after release -> LO=42, HI=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation encodings,
// FSM state encoding and the default operand width.
// Optional feature macro used by the sequencer: MULDIV_DIV_EN (divide support).
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Divide ops have op[1] set
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops have op[0] clear
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift/add-subtract datapath.
// Multiply: add the multiplicand when the current multiplier bit is set, then
// shift the 2*WIDTH accumulator right (LSB-first).
// Divide (only with MULDIV_DIV_EN): shift the next dividend bit into the
// partial remainder and keep the trial subtraction if it does not go negative
// (restoring division, MSB-first). Accumulator = {remainder, quotient}.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               is_div,
    input  logic               step_bit,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] mul_sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
`else
    logic unused_nodiv;
    assign unused_nodiv = &{1'b0, is_div, b_mag, acc[0]};
`endif

    // Single iteration: multiply path by default, divide path overrides it
    // NOTE: every signal written here gets a value first, so no latch is inferred.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (step_bit ? {1'b0, a_mag} : '0);
        acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        rem_shift = {acc[2*WIDTH-1:WIDTH], step_bit};
        trial     = rem_shift - {1'b0, b_mag};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// One operand bit per clock; HI/LO also accept direct writes while idle.
// Optional feature: define MULDIV_DIV_EN to build DIV/DIVU support; without it
// a divide start completes immediately with HI/LO unchanged.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH);

    state_e             state;
    state_e             state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;        // raw operand after start, magnitude after PREP
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;      // negate product / quotient
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               is_sgn;
    logic               step_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
`ifdef MULDIV_DIV_EN
    logic               neg_r;      // negate remainder
    logic               dbz_q;
    logic               b_zero;
    logic [CW-1:0]      div_idx;
`endif

    assign is_div = op_is_div(op_q);
    assign is_sgn = op_is_signed(op_q);

`ifdef MULDIV_DIV_EN
    assign b_zero        = (b_q == '0);
    assign div_idx       = CW'(WIDTH - 1) - cnt;
    assign step_bit      = is_div ? a_q[div_idx] : b_q[cnt];
    assign div_by_zero_o = dbz_q;
`else
    assign step_bit      = b_q[cnt];
    assign div_by_zero_o = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .step_bit (step_bit),
        .acc      (acc),
        .a_mag    (a_q),
        .b_mag    (b_q),
        .acc_next (acc_step)
    );

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-decoded status outputs
    always_comb begin
        state_nxt = state;
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        case (state)
            IDLE: begin
                if (start_i) begin
`ifdef MULDIV_DIV_EN
                    state_nxt = PREP;
`else
                    state_nxt = op_is_div(op_i) ? DONE : PREP;
`endif
                end
            end
            PREP: begin
                state_nxt = RUN;
`ifdef MULDIV_DIV_EN
                if (is_div && b_zero) begin
                    state_nxt = DONE;
                end
`endif
            end
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign correction of the raw accumulator into HI/LO results
    always_comb begin
        prod_fix = neg_q ? ('0 - acc) : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            res_lo = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            res_hi = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // Operand capture, iteration, sign fix and HI/LO writes
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
`ifdef MULDIV_DIV_EN
            neg_r <= 1'b0;
            dbz_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we_i) hi_o <= wdata_i;
                    if (lo_we_i) lo_o <= wdata_i;
                    if (start_i) begin
                        op_q <= op_i;
                        a_q  <= a_i;
                        b_q  <= b_i;
`ifdef MULDIV_DIV_EN
                        dbz_q <= 1'b0;
`endif
                    end
                end
                PREP: begin
                    a_q   <= (is_sgn && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
                    b_q   <= (is_sgn && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;
                    neg_q <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= '0;
`ifdef MULDIV_DIV_EN
                    neg_r <= is_sgn & a_q[WIDTH-1];
                    if (is_div && b_zero) begin
                        hi_o  <= a_q;
                        lo_o  <= '1;
                        dbz_q <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_o <= res_hi;
                    lo_o <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a 64-bit reference model computes each
// result, pushes it to a scoreboard queue, and a monitor pops and compares on
// every done_o pulse. Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         hi_we_i;
    logic         lo_we_i;
    logic [W-1:0] wdata_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         div_by_zero_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t ex;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int   d0;
    int   n;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .hi_we_i       (hi_we_i),
        .lo_we_i       (lo_we_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, independent of the iteration scheme
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hi0, input logic [W-1:0] lo0);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] u;
        e.hi  = hi0;
        e.lo  = lo0;
        e.dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p    = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                u    = {32'h0, a} * {32'h0, b};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    e.hi  = a;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    p    = sa / sb;
                    e.lo = p[31:0];
                    p    = sa % sb;
                    e.hi = p[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
`endif
            end
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (!op[1]) return W + 2;
`ifdef MULDIV_DIV_EN
        return (b == '0) ? 1 : W + 2;
`else
        return (b == b) ? 0 : 0;
`endif
    endfunction

    // Scoreboard monitor: compare on every done pulse
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_hi", hi_o, mon_e.hi);
                check("sb_lo", lo_o, mon_e.lo);
                check("sb_dbz", div_by_zero_o, mon_e.dbz);
            end
        end
    end

    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic hwe = 1'b0, input logic lwe = 1'b0, input logic [W-1:0] wd = '0);
        exp_t e;
        int   k;
        if (hwe) m_hi = wd;
        if (lwe) m_lo = wd;
        e = model(op, a, b, m_hi, m_lo);
        sb_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        hi_we_i = hwe; lo_we_i = lwe; wdata_i = wd;
        @(posedge clk); #1;
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        op_i = ~op; a_i = ~a; b_i = ~b;
        check({tag, "_busy"}, busy_o, 1);
        check({tag, "_dbz_clr"}, div_by_zero_o, 0);
        k = 0;
        while (done_o !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, exp_lat(op, b));
        @(posedge clk); #1;
        check({tag, "_idle"}, {busy_o, done_o}, 2'b00);
    endtask

    initial begin
        rst_b = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
        #1;
        check("rst_state", {busy_o, done_o, div_by_zero_o}, 3'b000);
        check("rst_hilo", {hi_o, lo_o}, 64'h0);
        #16 rst_b = 1'b0;

        // Direct writes while idle
        @(negedge clk); hi_we_i = 1'b1; wdata_i = 32'hABCD_1234;
        @(negedge clk); hi_we_i = 1'b0; lo_we_i = 1'b1; wdata_i = 32'h5555_0001;
        @(negedge clk); lo_we_i = 1'b0;
        m_hi = 32'hABCD_1234; m_lo = 32'h5555_0001;
        check("mthi", hi_o, m_hi);
        check("mtlo", lo_o, m_lo);

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi_o, 32'hFFFF_FFFE);
        check("multu_max_lo", lo_o, 32'h0000_0001);
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'h0);
        check("divu_zero_flag_hold", div_by_zero_o, m_hi == 32'h1234 && m_lo == 32'hFFFF_FFFF);
        do_op("after_dbz", OP_MULTU, 32'd3, 32'd5);
        do_op("wr_start", OP_MULT, 32'd100, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h5A5A_5A5A);
        do_op("wr_div", OP_DIVU, 32'd50, 32'd7, 1'b1, 1'b0, 32'h0000_0077);

        for (int i = 0; i < 6; i++) begin
            do_op("rand", 2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'h0 : $urandom);
        end

        // Start and MTHI/MTLO while busy must be ignored
        ex = model(OP_MULTU, 32'h0001_0003, 32'h0000_0011, m_hi, m_lo);
        sb_q.push_back(ex);
        m_hi = ex.hi; m_lo = ex.lo;
        d0 = n_done;
        @(negedge clk); start_i = 1'b1; op_i = OP_MULTU; a_i = 32'h0001_0003; b_i = 32'h0000_0011;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1; b_i = '0;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_DEAD;
        @(posedge clk); #1;
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        n = 12;
        while (done_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_ign_lat", n, W + 2);
        repeat (4) @(posedge clk);
        #1;
        check("busy_ign_pulses", n_done - d0, 1);
        check("busy_ign_hilo", {hi_o, lo_o}, {m_hi, m_lo});

        // Asynchronous reset mid-run
        @(negedge clk); start_i = 1'b1; op_i = OP_MULTU; a_i = 32'hFFFF_FFFF; b_i = 32'd3;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (17) @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        check("midrst_state", {busy_o, done_o, div_by_zero_o}, 3'b000);
        check("midrst_hilo", {hi_o, lo_o}, 64'h0);
        sb_q.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_b = 1'b0;
        do_op("post_rst", OP_MULTU, 32'd6, 32'd7);
        check("post_rst_hilo", {hi_o, lo_o}, 64'd42);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
